// File: rtl/cnn_state_integrator.sv
// Forward-Euler state integrator for the single-cell CNN compute block.
// Optional output/init clamp is enabled by defining CNN_STATE_CLAMP_EN.
module cnn_state_integrator #(
    parameter int WIDTH       = 9,
    parameter int N_CELLS     = 16,
    parameter int DT_SHIFT    = 3,
    parameter int MAX_ITER    = 64,
    parameter int CONV_THRESH = 0,
    parameter int CLAMP_MAG   = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [2*WIDTH-2:0]              x_init_in,
    input  logic                            init_valid,
    output logic [2*WIDTH-2:0]              x_out,
    output logic [$clog2(N_CELLS)-1:0]      cell_idx,
    output logic                            req,
    input  logic [2*WIDTH-2:0]              f_in,
    input  logic                            f_valid,
    output logic                            busy,
    output logic                            done,
    output logic                            converged,
    output logic [$clog2(MAX_ITER):0]       iter_count,
    input  logic [$clog2(N_CELLS)-1:0]      rd_addr,
    output logic [2*WIDTH-2:0]              rd_data
);

    localparam int SW = 2*WIDTH-1;
    localparam int IW = $clog2(N_CELLS);
    localparam int CW = $clog2(MAX_ITER)+1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_SWEEP = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [IW-1:0] LAST_IDX = IW'(N_CELLS-1);
    localparam logic [SW:0]   THRESH   = (SW+1)'(CONV_THRESH);
    localparam logic [CW-1:0] ITER_LIM = CW'(MAX_ITER);
    localparam logic signed [SW-1:0] CMAG = SW'(CLAMP_MAG);

`ifdef CNN_STATE_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif

    logic [2:0]    state;
    logic [IW-1:0] idx;
    logic [SW-1:0] xs [N_CELLS];
    logic [SW:0]   max_delta;
    logic [CW-1:0] iter_q;
    logic          conv_q;

    logic [SW-1:0]        cur;
    logic signed [SW:0]   diff;
    logic signed [SW:0]   delta;
    logic [SW:0]          abs_delta;
    logic [SW-1:0]        x_new;
    logic [SW-1:0]        wb_val;
    logic [SW-1:0]        init_val;
    logic                 last;

    function automatic logic [SW-1:0] clamp(input logic [SW-1:0] v);
        if ($signed(v) > CMAG)
            return CMAG;
        if ($signed(v) < -CMAG)
            return -CMAG;
        return v;
    endfunction

    // Result always lies between X and F, so the truncated add is exact.
    always_comb begin
        cur       = xs[idx];
        diff      = $signed({f_in[SW-1], f_in}) - $signed({cur[SW-1], cur});
        delta     = diff >>> DT_SHIFT;
        abs_delta = delta[SW] ? -delta : delta;
        x_new     = cur + delta[SW-1:0];
        wb_val    = CLAMP_ON ? clamp(x_new) : x_new;
        init_val  = CLAMP_ON ? clamp(x_init_in) : x_init_in;
        last      = (idx == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            iter_q    <= '0;
            conv_q    <= 1'b0;
            max_delta <= '0;
            for (int i = 0; i < N_CELLS; i++)
                xs[i] <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_LOAD;
                        idx    <= '0;
                        conv_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (init_valid) begin
                        xs[idx] <= init_val;
                        if (last) begin
                            state     <= S_SWEEP;
                            idx       <= '0;
                            iter_q    <= '0;
                            max_delta <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_SWEEP: begin
                    if (f_valid) begin
                        xs[idx] <= wb_val;
                        if (abs_delta > max_delta)
                            max_delta <= abs_delta;
                        if (last) begin
                            state <= S_CHECK;
                            idx   <= '0;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_CHECK: begin
                    iter_q <= iter_q + 1'b1;
                    if (max_delta <= THRESH) begin
                        state  <= S_DONE;
                        conv_q <= 1'b1;
                    end else if (iter_q + 1'b1 == ITER_LIM) begin
                        state  <= S_DONE;
                        conv_q <= 1'b0;
                    end else begin
                        state     <= S_SWEEP;
                        idx       <= '0;
                        max_delta <= '0;
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    assign x_out      = cur;
    assign cell_idx   = idx;
    assign req        = (state == S_SWEEP);
    assign busy       = (state != S_IDLE);
    assign done       = (state == S_DONE);
    assign converged  = conv_q;
    assign iter_count = iter_q;
    assign rd_data    = xs[rd_addr];

endmodule

// File: tb/tb_cnn_state_integrator.sv
// Randomized bench for cnn_state_integrator with an integer reference model.
// Expected values follow CNN_STATE_CLAMP_EN when it is defined.
module tb_cnn_state_integrator;

    localparam int WIDTH = 9;
    localparam int N     = 16;
    localparam int DTS   = 3;
    localparam int MAXI  = 4;
    localparam int THR   = 0;
    localparam int CM    = 4096;
    localparam int SW    = 2*WIDTH-1;
    localparam int IW    = $clog2(N);
    localparam int CW    = $clog2(MAXI)+1;
    localparam int S     = 1 << DTS;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [SW-1:0] x_init_in;
    logic          init_valid;
    logic [SW-1:0] x_out;
    logic [IW-1:0] cell_idx;
    logic          req;
    logic [SW-1:0] f_in;
    logic          f_valid;
    logic          busy;
    logic          done;
    logic          converged;
    logic [CW-1:0] iter_count;
    logic [IW-1:0] rd_addr;
    logic [SW-1:0] rd_data;

    int total = 0;
    int bad   = 0;
    int ld_x [N];
    int ld_f [N];
    int fin_x [N];

    cnn_state_integrator #(
        .WIDTH(WIDTH), .N_CELLS(N), .DT_SHIFT(DTS),
        .MAX_ITER(MAXI), .CONV_THRESH(THR), .CLAMP_MAG(CM)
    ) dut (
        .clk(clk), .rst(rst), .start(start),
        .x_init_in(x_init_in), .init_valid(init_valid),
        .x_out(x_out), .cell_idx(cell_idx), .req(req),
        .f_in(f_in), .f_valid(f_valid), .busy(busy),
        .done(done), .converged(converged),
        .iter_count(iter_count), .rd_addr(rd_addr),
        .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    // dt * (F - X), rounded toward minus infinity
    function automatic int mdelta(input int x, input int f);
        int d;
        d = f - x;
        if (d >= 0)
            return d / S;
        return -((-d + S - 1) / S);
    endfunction

    function automatic int mclamp(input int v);
`ifdef CNN_STATE_CLAMP_EN
        if (v > CM) return CM;
        if (v < -CM) return -CM;
`endif
        return v;
    endfunction

    function automatic int absi(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // mode 0: back-to-back, 1: valid pattern 1,0,0,1, 2: random gaps
    task automatic run_case(input int mode, input bit start_mid,
                            input string tag);
        int  mx [N];
        int  it;
        int  maxd;
        int  k;
        int  d;
        bit  v;
        bit  fin;
        bit  econv;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || req !== 1'b0) begin
            bad++;
            $display("FAIL %s load_flags: busy=%b req=%b want 1 0",
                     tag, busy, req);
        end
        for (int i = 0; i < N; i++) begin
            if (mode == 2 && $urandom_range(0, 2) == 0) begin
                init_valid = 1'b0;
                @(negedge clk);
            end
            total++;
            if (cell_idx !== IW'(i)) begin
                bad++;
                $display("FAIL %s load_idx: got %0d want %0d",
                         tag, cell_idx, i);
            end
            init_valid = 1'b1;
            x_init_in  = ld_x[i][SW-1:0];
            @(negedge clk);
            init_valid = 1'b0;
            mx[i] = mclamp(ld_x[i]);
        end
        it  = 0;
        fin = 1'b0;
        k   = 0;
        while (!fin) begin
            maxd = 0;
            for (int c = 0; c < N; c++) begin
                v = 1'b0;
                while (!v) begin
                    if (mode == 0)
                        v = 1'b1;
                    else if (mode == 1)
                        v = (k % 4 == 0) || (k % 4 == 3);
                    else
                        v = ($urandom_range(0, 2) != 0);
                    k++;
                    total++;
                    if (req !== 1'b1 || cell_idx !== IW'(c) ||
                        int'($signed(x_out)) !== mx[c]) begin
                        bad++;
                        $display("FAIL %s sweep%0d: req=%b idx=%0d x=%0d want 1 %0d %0d",
                                 tag, it, req, cell_idx,
                                 $signed(x_out), c, mx[c]);
                    end
                    start   = start_mid && it == 0 && c == 5;
                    f_valid = v;
                    f_in    = v ? ld_f[c][SW-1:0] : SW'($urandom);
                    if (v) begin
                        d = mdelta(mx[c], ld_f[c]);
                        if (absi(d) > maxd)
                            maxd = absi(d);
                        mx[c] = mclamp(mx[c] + d);
                    end
                    @(negedge clk);
                    f_valid = 1'b0;
                    start   = 1'b0;
                end
            end
            it++;
            total++;
            if (req !== 1'b0 || busy !== 1'b1 || done !== 1'b0) begin
                bad++;
                $display("FAIL %s check_state: req=%b busy=%b done=%b want 0 1 0",
                         tag, req, busy, done);
            end
            econv = (maxd <= THR);
            fin   = econv || (it == MAXI);
            @(negedge clk);
            if (fin) begin
                total++;
                if (done !== 1'b1 || converged !== econv ||
                    iter_count !== CW'(it)) begin
                    bad++;
                    $display("FAIL %s done: done=%b conv=%b iter=%0d want 1 %b %0d",
                             tag, done, converged, iter_count, econv, it);
                end
                @(negedge clk);
                total++;
                if (done !== 1'b0 || busy !== 1'b0 ||
                    converged !== econv) begin
                    bad++;
                    $display("FAIL %s idle: done=%b busy=%b conv=%b want 0 0 %b",
                             tag, done, busy, converged, econv);
                end
            end
        end
        for (int a = 0; a < N; a++) begin
            rd_addr = IW'(a);
            #1;
            total++;
            if (int'($signed(rd_data)) !== mx[a]) begin
                bad++;
                $display("FAIL %s readback[%0d]: got %0d want %0d",
                         tag, a, $signed(rd_data), mx[a]);
            end
            fin_x[a] = mx[a];
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || req !== 1'b0 || done !== 1'b0 ||
            converged !== 1'b0 || iter_count !== '0 ||
            cell_idx !== '0) begin
            bad++;
            $display("FAIL reset_flags: busy=%b req=%b done=%b conv=%b iter=%0d idx=%0d",
                     busy, req, done, converged, iter_count, cell_idx);
        end
        for (int a = 0; a < N; a++) begin
            rd_addr = IW'(a);
            #1;
            total++;
            if (rd_data !== '0) begin
                bad++;
                $display("FAIL reset_array[%0d]: got %0d want 0",
                         a, $signed(rd_data));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_single_update;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = 0;
            ld_f[i] = 800;
        end
        run_case(0, 1'b0, "iter_limit");
        rd_addr = IW'(7);
        #1;
        total++;
        if (int'($signed(rd_data)) !== 330) begin
            bad++;
            $display("FAIL iter_limit_const: got %0d want 330",
                     $signed(rd_data));
        end
    endtask

    task automatic test_ignored;
        @(negedge clk);
        init_valid = 1'b1;
        f_valid    = 1'b1;
        x_init_in  = SW'(123);
        f_in       = SW'(-4000);
        repeat (3) @(negedge clk);
        init_valid = 1'b0;
        f_valid    = 1'b0;
        for (int a = 0; a < N; a++) begin
            rd_addr = IW'(a);
            #1;
            total++;
            if (int'($signed(rd_data)) !== fin_x[a] || busy !== 1'b0) begin
                bad++;
                $display("FAIL ignored[%0d]: got %0d busy=%b want %0d 0",
                         a, $signed(rd_data), busy, fin_x[a]);
            end
        end
    endtask

    task automatic test_neg_rounding;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = 0;
            ld_f[i] = -9;
        end
        run_case(0, 1'b0, "neg_round");
    endtask

    task automatic test_fixed_point;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = 500;
            ld_f[i] = 500;
        end
        run_case(0, 1'b0, "fixed_point");
    endtask

    task automatic test_gaps;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = int'($urandom_range(0, 2000)) - 1000;
            ld_f[i] = ld_x[i] + int'($urandom_range(0, 30));
        end
        run_case(1, 1'b1, "gaps_start");
        for (int i = 0; i < N; i++) begin
            ld_x[i] = int'($urandom_range(0, 2000)) - 1000;
            ld_f[i] = int'($urandom_range(0, 4000)) - 2000;
        end
        run_case(2, 1'b0, "random_gaps");
    endtask

    task automatic test_clamp;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = 4000;
            ld_f[i] = 8000;
        end
        ld_x[3] = -6000;
        ld_f[3] = -9000;
        run_case(0, 1'b0, "clamp");
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) begin
                ld_x[i] = int'($urandom_range(0, 6000)) - 3000;
                if (r[0])
                    ld_f[i] = ld_x[i] + int'($urandom_range(0, 7));
                else
                    ld_f[i] = int'($urandom_range(0, 60000)) - 30000;
            end
            run_case(r % 3, 1'b0, "random");
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < N; i++) begin
            ld_x[i] = int'($urandom_range(1, 2000));
        end
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            init_valid = 1'b1;
            x_init_in  = ld_x[i][SW-1:0];
            @(negedge clk);
        end
        init_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            f_valid = 1'b1;
            f_in    = SW'(3000);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst     = 1'b0;
        f_valid = 1'b0;
        total++;
        if (busy !== 1'b0 || req !== 1'b0 || iter_count !== '0 ||
            converged !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_flags: busy=%b req=%b iter=%0d conv=%b",
                     busy, req, iter_count, converged);
        end
        for (int a = 0; a < N; a++) begin
            rd_addr = IW'(a);
            #1;
            total++;
            if (rd_data !== '0) begin
                bad++;
                $display("FAIL reset_mid_array[%0d]: got %0d want 0",
                         a, $signed(rd_data));
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        init_valid = 1'b0;
        f_valid    = 1'b0;
        x_init_in  = '0;
        f_in       = '0;
        rd_addr    = '0;
        test_reset;
        test_single_update;
        test_ignored;
        test_neg_rounding;
        test_fixed_point;
        test_gaps;
        test_clamp;
        test_random;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
